piso_tx_sched: RTL and testbench

- Scheduler/controller for the team's `piso` shift register (WIDTH-bit parallel load, MSB-first serial out).
- Two requesters share one serializer; a round-robin arbiter grants one word at a time.
- Generates the `piso` load/shift/parallel_in controls, frame framing and completion strobes.
- Sits between word producers and the serial link; `piso` is instantiated alongside it by the integrator.

---
 rtl/piso_tx_sched_if.sv | 32 +++
 rtl/piso_tx_sched.sv | 136 +++++++++++++
 tb/tb_piso_tx_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_sched_if.sv
// Handshake and serializer-control bundle between word producers, the
// piso_tx_sched scheduler and the attached piso shift register.
interface piso_tx_sched_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             piso_load;
  logic             piso_shift;
  logic [WIDTH-1:0] piso_data;
  logic             frame_valid;
  logic             grant_id;
  logic             busy;
  logic             done;

  // Producer / link side: drives requests, observes scheduler outputs.
  modport master (
    output en, req_valid, req_data0, req_data1,
    input  req_ready, piso_load, piso_shift, piso_data,
    input  frame_valid, grant_id, busy, done
  );

  // Scheduler side.
  modport slave (
    input  en, req_valid, req_data0, req_data1,
    output req_ready, piso_load, piso_shift, piso_data,
    output frame_valid, grant_id, busy, done
  );
endinterface

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler for two word producers sharing one MSB-first piso
// serializer: arbitrates, captures the word, then sequences LOAD/SHIFT/GAP.
module piso_tx_sched #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  piso_tx_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_e;

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;

  logic             winner;
  logic             accept;
  logic [1:0]       req_ready_c;

  // Priority requester wins if valid; otherwise the other one, so a lone
  // streamer is never blocked by the pointer.
  assign winner = bus.req_valid[prio_q] ? prio_q : ~prio_q;

  // Gated by rst so no handshake can complete while the block is held in reset.
  assign accept = rst && bus.en && (|bus.req_valid);

  // NOTE: every variable is given a default before the case so no path
  // leaves it unassigned -- that is what keeps this block free of latches.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    req_ready_c = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready_c[winner] = 1'b1;
          data_d              = winner ? bus.req_data1 : bus.req_data0;
          grant_d             = winner;
          prio_d              = ~winner;
          state_d             = S_LOAD;
        end
      end

      S_LOAD: begin
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
    end
  end

  // Strobes are pure decodes of registered state, so they are glitch-free
  // and drop to 0 the moment reset forces IDLE.
  assign bus.req_ready   = req_ready_c;
  assign bus.piso_load   = (state_q == S_LOAD);
  assign bus.piso_shift  = (state_q == S_SHIFT);
  assign bus.frame_valid = (state_q == S_SHIFT);
  assign bus.done        = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.piso_data   = data_q;

  a_load_shift_exclusive : assert property (
    @(posedge clk) disable iff (!rst) !(bus.piso_load && bus.piso_shift));

  a_ready_only_idle : assert property (
    @(posedge clk) disable iff (!rst)
    (bus.req_ready != 2'b00) |-> (state_q == S_IDLE && bus.en));

  a_ready_onehot : assert property (
    @(posedge clk) disable iff (!rst) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched: WIDTH=4/GAP=1 instance for framing,
// arbitration, enable and reset; WIDTH=8/GAP=0 instance for back-to-back frames.
module tb_piso_tx_sched;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  piso_tx_sched_if #(.WIDTH(4)) bus_a ();
  piso_tx_sched_if #(.WIDTH(8)) bus_b ();

  piso_tx_sched #(.WIDTH(4), .GAP_CYCLES(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  piso_tx_sched #(.WIDTH(8), .GAP_CYCLES(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural piso attached to instance A: MSB-first, zero fill.
  logic [3:0] sr_a;
  always @(posedge clk or negedge rst) begin
    if (!rst)                  sr_a <= '0;
    else if (bus_a.piso_load)  sr_a <= bus_a.piso_data;
    else if (bus_a.piso_shift) sr_a <= {sr_a[2:0], 1'b0};
  end

  // Packed view: {req_ready[1:0], load, shift, frame_valid, done, busy, grant_id}
  logic [7:0] obs_a, obs_b;
  assign obs_a = {bus_a.req_ready, bus_a.piso_load, bus_a.piso_shift,
                  bus_a.frame_valid, bus_a.done, bus_a.busy, bus_a.grant_id};
  assign obs_b = {bus_b.req_ready, bus_b.piso_load, bus_b.piso_shift,
                  bus_b.frame_valid, bus_b.done, bus_b.busy, bus_b.grant_id};

  task automatic apply_reset();
    @(negedge clk);
    rst             = 1'b0;
    bus_a.en        = 1'b0;
    bus_a.req_valid = 2'b00;
    bus_a.req_data0 = '0;
    bus_a.req_data1 = '0;
    bus_b.en        = 1'b0;
    bus_b.req_valid = 2'b00;
    bus_b.req_data0 = '0;
    bus_b.req_data1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    rst             = 1'b0;
    bus_a.en        = 1'b1;
    bus_a.req_valid = 2'b11;
    bus_a.req_data0 = 4'hF;
    bus_b.en        = 1'b1;
    bus_b.req_valid = 2'b01;
    #1;
    n_checks++;
    if (obs_a !== 8'h00) $display("FAIL reset_obs_a: got %h want 00", obs_a);
    else n_pass++;
    n_checks++;
    if (obs_b !== 8'h00) $display("FAIL reset_obs_b: got %h want 00", obs_b);
    else n_pass++;
    n_checks++;
    if (bus_a.piso_data !== 4'h0) $display("FAIL reset_piso_data: got %h want 0", bus_a.piso_data);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_obs [8] = '{8'h40, 8'h22, 8'h1A, 8'h1A, 8'h1A, 8'h1E, 8'h02, 8'h00};
    logic [3:0] exp_bits = 4'b1001;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus_a.en        = 1'b1;
        bus_a.req_valid = 2'b01;
        bus_a.req_data0 = 4'b1001;
      end else begin
        bus_a.req_valid = 2'b00;
        bus_a.req_data0 = 4'b0110;
      end
      #1;
      n_checks++;
      if (obs_a !== exp_obs[i]) $display("FAIL single_obs c%0d: got %h want %h", i, obs_a, exp_obs[i]);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (bus_a.piso_data !== 4'b1001) $display("FAIL single_load_data: got %b want 1001", bus_a.piso_data);
        else n_pass++;
      end
      if (i >= 2 && i <= 5) begin
        n_checks++;
        if (sr_a[3] !== exp_bits[5-i]) $display("FAIL single_serial c%0d: got %b want %b", i, sr_a[3], exp_bits[5-i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_alternating();
    logic [3:0] exp_data  [4] = '{4'hA, 4'h5, 4'hA, 4'h5};
    logic       exp_grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n_load = 0;
    int n_bad  = 0;
    apply_reset();
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus_a.en        = 1'b1;
        bus_a.req_valid = 2'b11;
        bus_a.req_data0 = 4'hA;
        bus_a.req_data1 = 4'h5;
      end
      #1;
      if (bus_a.req_ready == 2'b11 || (bus_a.req_ready != 2'b00 && bus_a.busy)) n_bad++;
      if (bus_a.piso_load) begin
        if (n_load < 4) begin
          n_checks++;
          if ({8'(i), bus_a.grant_id, bus_a.piso_data} !== {8'(1 + 7*n_load), exp_grant[n_load], exp_data[n_load]})
            $display("FAIL alt_frame%0d: got cyc=%0d g=%0d d=%h want cyc=%0d g=%0d d=%h",
                     n_load, i, bus_a.grant_id, bus_a.piso_data, 1 + 7*n_load, exp_grant[n_load], exp_data[n_load]);
          else n_pass++;
        end
        n_load++;
      end
    end
    n_checks++;
    if (n_load !== 4) $display("FAIL alt_load_count: got %0d want 4", n_load);
    else n_pass++;
    n_checks++;
    if (n_bad !== 0) $display("FAIL alt_ready_rules: got %0d violations want 0", n_bad);
    else n_pass++;
  endtask

  task automatic test_single_requester();
    int n_load = 0;
    int n_r1   = 0;
    int n_r0   = 0;
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus_a.en        = 1'b1;
        bus_a.req_valid = 2'b10;
        bus_a.req_data0 = 4'hE;
        bus_a.req_data1 = 4'h3;
      end
      #1;
      if (bus_a.req_ready[0]) n_r0++;
      if (bus_a.req_ready[1]) n_r1++;
      if (bus_a.piso_load) begin
        n_checks++;
        if ({8'(i), bus_a.grant_id, bus_a.piso_data} !== {8'(1 + 7*n_load), 1'b1, 4'h3})
          $display("FAIL solo_frame%0d: got cyc=%0d g=%0d d=%h want cyc=%0d g=1 d=3",
                   n_load, i, bus_a.grant_id, bus_a.piso_data, 1 + 7*n_load);
        else n_pass++;
        n_load++;
      end
    end
    n_checks++;
    if (n_r1 !== 3) $display("FAIL solo_ready1_count: got %0d want 3", n_r1);
    else n_pass++;
    n_checks++;
    if (n_r0 !== 0) $display("FAIL solo_ready0_count: got %0d want 0", n_r0);
    else n_pass++;
  endtask

  task automatic test_enable();
    logic [7:0] exp_obs [14] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h22,
                                 8'h1A, 8'h1A, 8'h1A, 8'h1E, 8'h02, 8'h00, 8'h00};
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus_a.req_valid = 2'b01;
      bus_a.req_data0 = 4'h6;
      bus_a.en        = (i == 5 || i == 6);
      #1;
      n_checks++;
      if (obs_a !== exp_obs[i]) $display("FAIL enable_obs c%0d: got %h want %h", i, obs_a, exp_obs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp_obs [4] = '{8'h40, 8'h22, 8'h1A, 8'h1A};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.en        = 1'b1;
      bus_a.req_valid = 2'b01;
      bus_a.req_data0 = 4'h9;
      #1;
      n_checks++;
      if (obs_a !== exp_obs[i]) $display("FAIL rstmid_pre c%0d: got %h want %h", i, obs_a, exp_obs[i]);
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({obs_a, bus_a.piso_data} !== 12'h000) $display("FAIL rstmid_abort: got obs=%h d=%h want 00/0", obs_a, bus_a.piso_data);
    else n_pass++;
    @(negedge clk);
    rst             = 1'b1;
    bus_a.req_valid = 2'b11;
    bus_a.req_data1 = 4'hC;
    #1;
    n_checks++;
    if (obs_a !== 8'h40) $display("FAIL rstmid_prio: got %h want 40", obs_a);
    else n_pass++;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      bus_a.req_valid = 2'b10;
      #1;
      if (j == 7) begin
        n_checks++;
        if (obs_a !== 8'h80) $display("FAIL rstmid_req1_ready: got %h want 80", obs_a);
        else n_pass++;
      end
      if (j == 8) begin
        n_checks++;
        if ({obs_a, bus_a.piso_data} !== {8'h23, 4'hC}) $display("FAIL rstmid_req1_load: got %h/%h want 23/c", obs_a, bus_a.piso_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n_load    = 0;
    int   n_pairs   = 0;
    int   n_bad     = 0;
    logic prev_done = 1'b0;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus_b.en        = 1'b1;
        bus_b.req_valid = 2'b01;
        bus_b.req_data0 = 8'hB4;
      end
      #1;
      if (prev_done) begin
        n_pairs++;
        if (bus_b.req_ready !== 2'b01) n_bad++;
      end
      prev_done = bus_b.done;
      if (bus_b.piso_load) begin
        n_checks++;
        if ({8'(i), bus_b.grant_id, bus_b.piso_data} !== {8'(1 + 10*n_load), 1'b0, 8'hB4})
          $display("FAIL b2b_frame%0d: got cyc=%0d g=%0d d=%h want cyc=%0d g=0 d=b4",
                   n_load, i, bus_b.grant_id, bus_b.piso_data, 1 + 10*n_load);
        else n_pass++;
        n_load++;
      end
    end
    n_checks++;
    if ({8'(n_load), 8'(n_pairs), 8'(n_bad)} !== {8'd3, 8'd2, 8'd0})
      $display("FAIL b2b_counts: got loads=%0d pairs=%0d bad=%0d want 3/2/0", n_load, n_pairs, n_bad);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_single_frame();
    test_alternating();
    test_single_requester();
    test_enable();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
